gamma_lut_prog: RTL and testbench
=================================

# gamma_lut_prog

Programmable, multi-channel gamma correction stage for the ISP pixel pipeline. Each colour channel has its own register-based lookup table, loaded through a simple config port driven by the AHB slave. Pixels are mapped through linear interpolation between adjacent table entries. The stage has a two-deep valid/ready pipeline and sits between demosaic/colour correction and the output formatter.

## Interface
- `DATA_W`, 8: pixel component width; must be ≥ `LUT_AW`+1.
- `LUT_AW`, 6: table address width; each channel has 2^`LUT_AW` entries of `DATA_W` bits. `FW` = `DATA_W`−`LUT_AW`.
- `NCH`, 3: number of channels.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: input pixel valid.
- `in_ready`, out, 1: stage can accept the input pixel.
- `in_data`, in, `NCH`*`DATA_W`: channel c is at [c*`DATA_W` +: `DATA_W`].
- `out_valid`, out, 1: output pixel valid.
- `out_ready`, in, 1: downstream accepts the output pixel.
- `out_data`, out, `NCH`*`DATA_W`: corrected pixel, same packing as `in_data`.
- `cfg_bypass`, in, 1: when 1, pass the pixel through unchanged.
- `cfg_interp`, in, 1: 1 selects linear interpolation; 0 selects the lower entry only.
- `cfg_we`, in, 1: table write strobe.
- `cfg_re`, in, 1: table read strobe.
- `cfg_ch`, in, clog2(`NCH`) (minimum 1): channel select.
- `cfg_addr`, in, `LUT_AW`: entry index.
- `cfg_wdata`, in, `DATA_W`: write data.
- `cfg_rdata`, out, `DATA_W`: read data, registered.
- `cfg_rvalid`, out, 1: one-cycle pulse, `cfg_rdata` is valid.

## Operation
- **Table reset (identity):** entry k = k << `FW` in every channel.
- **Table write:** when `cfg_we`=1, entry [`cfg_ch`][`cfg_addr`] is updated at the clock edge.
  - A pixel sampled in the same cycle sees the old value.
  - Out-of-range `cfg_ch` values (≥ `NCH`) are ignored.
- **Table read:** `cfg_re`=1 returns the entry on `cfg_rdata`, with `cfg_rvalid` high, on the next cycle.
  - If `cfg_re` and `cfg_we` hit the same entry in the same cycle, the read returns the old value.
  - An out-of-range channel reads as 0.
- **Stage 1 (lookup):** per channel, compute idx = pix[`DATA_W`−1:`FW`] and frac = pix[`FW`−1:0].
  - Register e0 = T[idx].
  - Register e1 = T[idx+1], except when idx = 2^`LUT_AW`−1, where e1 = 2^`DATA_W` (a `DATA_W`+1-bit virtual endpoint).
  - Also register frac, the raw pixel, `cfg_bypass` and `cfg_interp`. The mode bits therefore apply per pixel.
- **Stage 2 (compute):**
  - Bypass: out = pix.
  - Interpolation off: out = e0.
  - Interpolation on: out = e0 + ((e1−e0)*frac + 2^(`FW`−1)) >>> `FW`, computed signed at width `DATA_W`+`FW`+2, with an arithmetic (floor) shift. The result is clamped to [0, 2^`DATA_W`−1].
  - Descending tables are legal.
- **Pipeline handshake:**
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - `in_ready` = s1_adv.
  - A transfer happens when valid and ready are both high. Nothing is dropped or duplicated, and order is preserved.
  - `out_data` is held stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Latency is 2 cycles from input acceptance to `out_valid`, independent of mode.
- Throughput is 1 pixel/cycle while `out_ready`=1.
- Reset values:
  - `out_valid`=0, `out_data`=0.
  - `cfg_rdata`=0, `cfg_rvalid`=0.
  - Internal valids = 0; tables = identity.
  - `in_ready`=1 from the first cycle after reset deasserts.
- Reset mid-stream discards all in-flight pixels and restores the identity tables.
- When `out_ready` is low with both stages full, `in_ready`=0 in that same cycle (combinational).
- Config and pixel ports are independent: a write in cycle n affects pixels accepted in cycle n+1 or later.

## Test plan
All scenarios use the defaults (`DATA_W`=8, `LUT_AW`=6, `NCH`=3).

1. **Identity after reset:** inputs {0x00, 0x80, 0xFF} on all channels with interp on → identical outputs, 2 cycles later.
2. **Ascending segment:** write ch0 T[10]=100, T[11]=120, then input ch0=42 (idx 10, frac 2) → 110. Same input with `cfg_interp`=0 → 100. Ch1/ch2 unchanged (identity).
3. **Descending segment:** ch1 T[10]=200, T[11]=100, input 43 (frac 3) → 125. Top segment: ch2 T[63]=250, input 255 → 250+((6*3+2)>>>2)=255, with no overflow.
4. **Backpressure:** hold `out_ready`=0 and offer 4 pixels.
   - Only 2 are accepted and `in_ready` drops.
   - After `out_ready`=1, all 4 emerge in order with no gaps beyond 1 pixel/cycle.
   - `out_data` is stable throughout the stall.
5. **Config collision:** `cfg_we` to ch0[5]=7 and `cfg_re` ch0[5] in the same cycle → `cfg_rdata`=20 (old value). A pixel accepted that cycle uses 20; the next read returns 7.
6. **Reset mid-operation:** assert `rst_n`=0 with 2 pixels in flight and a modified table.
   - `out_valid` goes 0 immediately (asynchronous).
   - After release, input 42 on ch0 → 42 (identity restored).

Source files
------------

// File: rtl/gamma_lut_prog_if.sv
// Pixel stream handshake and table configuration port of the gamma LUT stage.
// The slave modport is the stage; master is the upstream, downstream and config side.
interface gamma_lut_prog_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LUT_AW = 6,
   parameter int unsigned NCH    = 3
);
   localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned PW   = NCH * DATA_W;

   logic              in_valid;
   logic              in_ready;
   logic [PW-1:0]     in_data;
   logic              out_valid;
   logic              out_ready;
   logic [PW-1:0]     out_data;
   logic              cfg_bypass;
   logic              cfg_interp;
   logic              cfg_we;
   logic              cfg_re;
   logic [CH_W-1:0]   cfg_ch;
   logic [LUT_AW-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_wdata;
   logic [DATA_W-1:0] cfg_rdata;
   logic              cfg_rvalid;

   modport slave (
      input  in_valid, in_data, out_ready,
      input  cfg_bypass, cfg_interp, cfg_we, cfg_re, cfg_ch, cfg_addr, cfg_wdata,
      output in_ready, out_valid, out_data, cfg_rdata, cfg_rvalid
   );

   modport master (
      output in_valid, in_data, out_ready,
      output cfg_bypass, cfg_interp, cfg_we, cfg_re, cfg_ch, cfg_addr, cfg_wdata,
      input  in_ready, out_valid, out_data, cfg_rdata, cfg_rvalid
   );
endinterface

// File: rtl/gamma_lut_prog.sv
// Programmable per-channel gamma LUT with linear interpolation between entries.
// Two-stage valid/ready pipeline: table lookup, then interpolate/clamp.
module gamma_lut_prog #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LUT_AW = 6,
   parameter int unsigned NCH    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   gamma_lut_prog_if.slave  bus
);
   localparam int unsigned FW   = DATA_W - LUT_AW;
   localparam int unsigned NENT = 1 << LUT_AW;
   localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned PW   = NCH * DATA_W;
   localparam int unsigned IW   = DATA_W + FW + 2;
   localparam int unsigned HALF = 1 << (FW - 1);
   localparam int unsigned MAXV = (1 << DATA_W) - 1;

   logic [DATA_W-1:0] lut [NCH][NENT];

   logic              s1_valid;
   logic [PW-1:0]     s1_pix;
   logic              s1_bypass;
   logic              s1_interp;
   logic              out_valid_q;
   logic [PW-1:0]     out_data_q;
   logic [PW-1:0]     out_c;
   logic              s2_adv_c;
   logic              s1_adv_c;
   logic              ld_c;
   logic [DATA_W-1:0] rd_c;
   logic [DATA_W-1:0] cfg_rdata_q;
   logic              cfg_rvalid_q;

   // Tables: identity on reset; writes to channels outside [0,NCH) match nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < int'(NCH); c++)
            for (int k = 0; k < int'(NENT); k++)
               lut[c][k] <= DATA_W'(k << FW);
      end else begin
         for (int c = 0; c < int'(NCH); c++)
            if (bus.cfg_we && (bus.cfg_ch == CH_W'(c)))
               lut[c][bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   always_comb begin
      rd_c = '0;
      for (int c = 0; c < int'(NCH); c++)
         if (bus.cfg_ch == CH_W'(c))
            rd_c = lut[c][bus.cfg_addr];
   end

   // Registered readback sees the table before a same-cycle write lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_rdata_q  <= '0;
         cfg_rvalid_q <= 1'b0;
      end else begin
         cfg_rvalid_q <= bus.cfg_re;
         if (bus.cfg_re)
            cfg_rdata_q <= rd_c;
      end
   end

   assign s2_adv_c = ~out_valid_q | bus.out_ready;
   assign s1_adv_c = ~s1_valid | s2_adv_c;
   assign ld_c     = bus.in_valid & s1_adv_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_pix    <= '0;
         s1_bypass <= 1'b0;
         s1_interp <= 1'b0;
      end else begin
         if (s1_adv_c)
            s1_valid <= bus.in_valid;
         if (ld_c) begin
            s1_pix    <= bus.in_data;
            s1_bypass <= bus.cfg_bypass;
            s1_interp <= bus.cfg_interp;
         end
      end
   end

   for (genvar c = 0; c < int'(NCH); c++) begin : g_ch
      logic [LUT_AW-1:0]    idx_c;
      logic [FW-1:0]        frac_c;
      logic [DATA_W-1:0]    e0_c;
      logic [DATA_W:0]      e1_c;
      logic [DATA_W-1:0]    s1_e0;
      logic [DATA_W:0]      s1_e1;
      logic [FW-1:0]        s1_frac;
      logic signed [IW-1:0] diff_c;
      logic signed [IW-1:0] prod_c;
      logic signed [IW-1:0] sum_c;
      logic [DATA_W-1:0]    clamp_c;
      logic [DATA_W-1:0]    res_c;

      assign idx_c  = bus.in_data[c*DATA_W+FW +: LUT_AW];
      assign frac_c = bus.in_data[c*DATA_W +: FW];

      // Upper endpoint of the top segment is the virtual value 2^DATA_W.
      always_comb begin
         e0_c = lut[c][idx_c];
         if (&idx_c)
            e1_c = {1'b1, {DATA_W{1'b0}}};
         else
            e1_c = {1'b0, lut[c][idx_c + LUT_AW'(1)]};
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_e0   <= '0;
            s1_e1   <= '0;
            s1_frac <= '0;
         end else if (ld_c) begin
            s1_e0   <= e0_c;
            s1_e1   <= e1_c;
            s1_frac <= frac_c;
         end
      end

      // Signed slope handles descending tables; floor shift after half-LSB rounding.
      always_comb begin
         diff_c = $signed(IW'(s1_e1)) - $signed(IW'(s1_e0));
         prod_c = diff_c * $signed(IW'(s1_frac));
         sum_c  = $signed(IW'(s1_e0)) + ((prod_c + $signed(IW'(HALF))) >>> FW);
         if (sum_c[IW-1])
            clamp_c = '0;
         else if (sum_c > $signed(IW'(MAXV)))
            clamp_c = DATA_W'(MAXV);
         else
            clamp_c = sum_c[DATA_W-1:0];

         if (s1_bypass)
            res_c = s1_pix[c*DATA_W +: DATA_W];
         else if (!s1_interp)
            res_c = s1_e0;
         else
            res_c = clamp_c;
      end

      assign out_c[c*DATA_W +: DATA_W] = res_c;
   end

   // Output register holds while stalled; advances when empty or drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (s2_adv_c) begin
         out_valid_q <= s1_valid;
         if (s1_valid)
            out_data_q <= out_c;
      end
   end

   assign bus.in_ready   = s1_adv_c;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.cfg_rdata  = cfg_rdata_q;
   assign bus.cfg_rvalid = cfg_rvalid_q;

endmodule

// File: tb/tb_gamma_lut_prog.sv
// Directed bench for gamma_lut_prog with hand-computed expected pixels and readbacks.
module tb_gamma_lut_prog;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned LUT_AW = 6;
   localparam int unsigned NCH    = 3;
   localparam int unsigned CH_W   = 2;
   localparam int unsigned PW     = NCH * DATA_W;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   gamma_lut_prog_if #(.DATA_W(DATA_W), .LUT_AW(LUT_AW), .NCH(NCH)) bus ();

   gamma_lut_prog #(.DATA_W(DATA_W), .LUT_AW(LUT_AW), .NCH(NCH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_pix(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_byte(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [LUT_AW-1:0] addr,
                            input logic [DATA_W-1:0] data);
      bus.cfg_we    = 1'b1;
      bus.cfg_ch    = ch;
      bus.cfg_addr  = addr;
      bus.cfg_wdata = data;
      tick();
      bus.cfg_we    = 1'b0;
   endtask

   task automatic cfg_read(input string tag, input logic [CH_W-1:0] ch,
                           input logic [LUT_AW-1:0] addr, input logic [DATA_W-1:0] exp);
      bus.cfg_re   = 1'b1;
      bus.cfg_ch   = ch;
      bus.cfg_addr = addr;
      tick();
      bus.cfg_re   = 1'b0;
      chk_bit(tag, bus.cfg_rvalid, 1'b1);
      chk_byte(tag, bus.cfg_rdata, exp);
   endtask

   // One pixel through an idle pipeline: out_valid must appear exactly two edges later.
   task automatic send_pix(input string tag, input logic [PW-1:0] d, input logic byp,
                           input logic interp, input logic [PW-1:0] exp);
      bus.in_data    = d;
      bus.cfg_bypass = byp;
      bus.cfg_interp = interp;
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid   = 1'b0;
      chk_bit(tag, bus.out_valid, 1'b0);
      tick();
      chk_bit(tag, bus.out_valid, 1'b1);
      chk_pix(tag, bus.out_data, exp);
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;
      bus.cfg_bypass = 1'b0;
      bus.cfg_interp = 1'b1;
      bus.cfg_we     = 1'b0;
      bus.cfg_re     = 1'b0;
      bus.cfg_ch     = '0;
      bus.cfg_addr   = '0;
      bus.cfg_wdata  = '0;

      // Reset state
      repeat (3) tick();
      chk_bit("rst_out_valid", bus.out_valid, 1'b0);
      chk_pix("rst_out_data", bus.out_data, 24'h000000);
      chk_bit("rst_rvalid", bus.cfg_rvalid, 1'b0);
      chk_byte("rst_rdata", bus.cfg_rdata, 8'h00);
      rst_n = 1'b1;
      tick();
      chk_bit("rst_in_ready", bus.in_ready, 1'b1);

      // Identity tables after reset
      send_pix("id_00", 24'h000000, 1'b0, 1'b1, 24'h000000);
      send_pix("id_80", 24'h808080, 1'b0, 1'b1, 24'h808080);
      send_pix("id_ff", 24'hFFFFFF, 1'b0, 1'b1, 24'hFFFFFF);
      cfg_read("id_rd_c2_63", 2'd2, 6'd63, 8'd252);

      // Ascending segment on ch0: 100 -> 120, pixel 42 (idx 10, frac 2)
      cfg_write(2'd0, 6'd10, 8'd100);
      cfg_write(2'd0, 6'd11, 8'd120);
      send_pix("asc_interp", 24'h2A2A2A, 1'b0, 1'b1, 24'h2A2A6E);
      send_pix("asc_lower", 24'h2A2A2A, 1'b0, 1'b0, 24'h282864);
      send_pix("asc_bypass", 24'h2A2A2A, 1'b1, 1'b1, 24'h2A2A2A);

      // Descending segment on ch1 and top segment on ch2
      cfg_write(2'd1, 6'd10, 8'd200);
      cfg_write(2'd1, 6'd11, 8'd100);
      cfg_write(2'd2, 6'd63, 8'd250);
      send_pix("desc_top", 24'hFF2B00, 1'b0, 1'b1, 24'hFF7D00);

      // Out-of-range channel: write ignored, reads as zero
      cfg_write(2'd3, 6'd0, 8'hAA);
      cfg_read("oor_rd", 2'd3, 6'd0, 8'h00);
      cfg_read("oor_c0_0", 2'd0, 6'd0, 8'h00);
      cfg_read("rd_c0_10", 2'd0, 6'd10, 8'd100);

      // Backpressure: two accepted, stall holds output, then drain in order
      bus.out_ready  = 1'b0;
      bus.cfg_bypass = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_data    = 24'h111111;
      chk_bit("bp_rdy0", bus.in_ready, 1'b1);
      tick();
      bus.in_data = 24'h222222;
      chk_bit("bp_rdy1", bus.in_ready, 1'b1);
      chk_bit("bp_ov1", bus.out_valid, 1'b0);
      tick();
      bus.in_data = 24'h333333;
      chk_bit("bp_rdy2", bus.in_ready, 1'b0);
      chk_bit("bp_ov2", bus.out_valid, 1'b1);
      chk_pix("bp_p0", bus.out_data, 24'h111111);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_bit("bp_stall_ov", bus.out_valid, 1'b1);
         chk_pix("bp_stall_p0", bus.out_data, 24'h111111);
         chk_bit("bp_stall_rdy", bus.in_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk_bit("bp_rdy_comb", bus.in_ready, 1'b1);
      tick();
      bus.in_data = 24'h444444;
      chk_pix("bp_p1", bus.out_data, 24'h222222);
      tick();
      bus.in_valid = 1'b0;
      chk_pix("bp_p2", bus.out_data, 24'h333333);
      tick();
      chk_bit("bp_ov3", bus.out_valid, 1'b1);
      chk_pix("bp_p3", bus.out_data, 24'h444444);
      tick();
      chk_bit("bp_drained", bus.out_valid, 1'b0);
      bus.cfg_bypass = 1'b0;

      // Write/read/pixel collision on ch0[5]: all see the old value 20
      bus.cfg_we     = 1'b1;
      bus.cfg_re     = 1'b1;
      bus.cfg_ch     = 2'd0;
      bus.cfg_addr   = 6'd5;
      bus.cfg_wdata  = 8'd7;
      bus.in_data    = 24'h000014;
      bus.cfg_interp = 1'b1;
      bus.in_valid   = 1'b1;
      tick();
      bus.cfg_we   = 1'b0;
      bus.cfg_re   = 1'b0;
      bus.in_valid = 1'b0;
      chk_bit("col_rvalid", bus.cfg_rvalid, 1'b1);
      chk_byte("col_rdata", bus.cfg_rdata, 8'd20);
      tick();
      chk_bit("col_rvalid_pulse", bus.cfg_rvalid, 1'b0);
      chk_bit("col_pix_ov", bus.out_valid, 1'b1);
      chk_pix("col_pix_old", bus.out_data, 24'h000014);
      cfg_read("col_rd_new", 2'd0, 6'd5, 8'd7);
      send_pix("col_pix_new", 24'h000014, 1'b0, 1'b1, 24'h000007);

      // Reset with two pixels in flight and modified tables
      bus.in_valid = 1'b1;
      bus.in_data  = 24'h2A2A2A;
      tick();
      bus.in_data  = 24'h111111;
      tick();
      bus.in_valid = 1'b0;
      chk_bit("mid_ov_before", bus.out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_bit("mid_ov_async", bus.out_valid, 1'b0);
      chk_pix("mid_od_async", bus.out_data, 24'h000000);
      tick();
      rst_n = 1'b1;
      tick();
      chk_bit("mid_ov_after", bus.out_valid, 1'b0);
      send_pix("mid_identity", 24'h2A2A2A, 1'b0, 1'b1, 24'h2A2A2A);
      cfg_read("mid_rd_c1_10", 2'd1, 6'd10, 8'd40);
      cfg_read("mid_rd_c0_5", 2'd0, 6'd5, 8'd20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
